demux_conductual: RTL and testbench

DEMUX_CONDUCTUAL -- requirements
Module: demux_conductual

---
 rtl/demux_conductual.sv | 135 +++++++++++++
 tb/tb_demux_conductual.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_conductual.sv
// -----------------------------------------------------------------------------
// demux_conductual
//
// Purpose:
//   Splits a time-multiplexed word stream into two lanes. The first qualified
//   word of a pair is held internally (lane 0). The second qualified word
//   (lane 1) completes the pair. Both words are then presented together on
//   data_out_0 and data_out_1 with a one-cycle valid_out pulse. If a lane 0
//   word waits too long for its partner, it is discarded and err_timeout
//   pulses for one cycle.
//
// Ports:
//   clk         in   1      rising-edge clock for all state
//   reset_L     in   1      asynchronous active-low reset
//   data_in     in   WIDTH  multiplexed stream: lane 0 word, then lane 1 word
//   valid_in    in   1      data_in qualifier
//   data_out_0  out  WIDTH  reconstructed lane 0 word (held between pairs)
//   data_out_1  out  WIDTH  reconstructed lane 1 word (held between pairs)
//   valid_out   out  1      one-cycle pulse: a new pair is on the outputs
//   err_timeout out  1      one-cycle pulse: a partial pair was discarded
//   pair_count  out  8      pairs delivered since reset, wraps 255 -> 0
//
// Parameters:
//   WIDTH    lane data width in bits
//   TIMEOUT  idle cycles tolerated in LANE1 before the held word is dropped
//            (legal range 1..15; the idle counter is 4 bits wide)
// -----------------------------------------------------------------------------
module demux_conductual #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic             valid_out,
  output logic             err_timeout,
  output logic [7:0]       pair_count
);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } state_t;

  // Idle count at which the next empty edge in LANE1 triggers the timeout.
  localparam logic [3:0] IDLE_LAST = 4'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic [3:0]       idle_q,  idle_d;
  logic [WIDTH-1:0] out0_q,  out0_d;
  logic [WIDTH-1:0] out1_q,  out1_d;
  logic             vld_q,   vld_d;
  logic             err_q,   err_d;
  logic [7:0]       cnt_q,   cnt_d;

  // Next-state and registered-output logic for the two-lane FSM.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idle_d  = 4'd0;        // counter is held at 0 unless waiting in LANE1
    out0_d  = out0_q;
    out1_d  = out1_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      LANE0: begin
        if (valid_in) begin
          hold_d  = data_in;
          state_d = LANE1;
        end else begin
          state_d = LANE0;
        end
      end

      LANE1: begin
        // A valid word always wins, even on the edge that would time out.
        if (valid_in) begin
          out0_d  = hold_q;
          out1_d  = data_in;
          vld_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = LANE0;
        end else if (idle_q == IDLE_LAST) begin
          hold_d  = {WIDTH{1'b0}};
          err_d   = 1'b1;
          state_d = LANE0;
        end else begin
          idle_d  = idle_q + 4'd1;
          state_d = LANE1;
        end
      end

      default: begin
        state_d = LANE0;
        hold_d  = {WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= LANE0;
      hold_q  <= {WIDTH{1'b0}};
      idle_q  <= 4'd0;
      out0_q  <= {WIDTH{1'b0}};
      out1_q  <= {WIDTH{1'b0}};
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idle_q  <= idle_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out_0  = out0_q;
  assign data_out_1  = out1_q;
  assign valid_out   = vld_q;
  assign err_timeout = err_q;
  assign pair_count  = cnt_q;

endmodule

// File: tb/tb_demux_conductual.sv
// -----------------------------------------------------------------------------
// tb_demux_conductual
//
// Directed bench for demux_conductual (WIDTH=4, TIMEOUT=4). Inputs change on
// the falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_demux_conductual;

  logic       clk;
  logic       reset_L;
  logic [3:0] data_in;
  logic       valid_in;
  logic [3:0] data_out_0;
  logic [3:0] data_out_1;
  logic       valid_out;
  logic       err_timeout;
  logic [7:0] pair_count;

  int n_cmp;
  int n_err;

  demux_conductual #(.WIDTH(4), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .valid_out  (valid_out),
    .err_timeout(err_timeout),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input cycle and advance past the sampling edge.
  task automatic step(input logic v, input logic [3:0] d);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L  = 1'b1;
    valid_in = 1'b0;
    data_in  = 4'h0;
    #1;
    reset_L = 1'b0;
    #2;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    n_cmp++; if (data_out_0 !== 4'h0) begin n_err++; $display("FAIL reset_d0: got %h want 0", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'h0) begin n_err++; $display("FAIL reset_d1: got %h want 0", data_out_1); end
    n_cmp++; if (pair_count !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", pair_count); end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_pair();
    step(1'b1, 4'hA);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL pair_first_valid: got %b want 0", valid_out); end
    step(1'b1, 4'h5);
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL pair_valid: got %b want 1", valid_out); end
    n_cmp++; if (data_out_0 !== 4'hA) begin n_err++; $display("FAIL pair_d0: got %h want a", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'h5) begin n_err++; $display("FAIL pair_d1: got %h want 5", data_out_1); end
    n_cmp++; if (pair_count !== 8'd1) begin n_err++; $display("FAIL pair_cnt: got %0d want 1", pair_count); end
    step(1'b0, 4'h0);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL pair_pulse_end: got %b want 0", valid_out); end
    n_cmp++; if (data_out_0 !== 4'hA) begin n_err++; $display("FAIL pair_hold_d0: got %h want a", data_out_0); end
  endtask

  task automatic test_gap();
    step(1'b1, 4'h3);
    step(1'b0, 4'hE);
    step(1'b0, 4'hE);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL gap_early_valid: got %b want 0", valid_out); end
    step(1'b1, 4'hC);
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL gap_valid: got %b want 1", valid_out); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL gap_err: got %b want 0", err_timeout); end
    n_cmp++; if (data_out_0 !== 4'h3) begin n_err++; $display("FAIL gap_d0: got %h want 3", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'hC) begin n_err++; $display("FAIL gap_d1: got %h want c", data_out_1); end
    n_cmp++; if (pair_count !== 8'd2) begin n_err++; $display("FAIL gap_cnt: got %0d want 2", pair_count); end
  endtask

  task automatic test_timeout();
    step(1'b1, 4'h7);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'h0);
      n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_early_err[%0d]: got %b want 0", k, err_timeout); end
    end
    step(1'b0, 4'h0);
    n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", err_timeout); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL to_valid: got %b want 0", valid_out); end
    n_cmp++; if (data_out_0 !== 4'h3) begin n_err++; $display("FAIL to_d0_held: got %h want 3", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'hC) begin n_err++; $display("FAIL to_d1_held: got %h want c", data_out_1); end
    n_cmp++; if (pair_count !== 8'd2) begin n_err++; $display("FAIL to_cnt: got %0d want 2", pair_count); end
    step(1'b0, 4'h0);
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_err_pulse_end: got %b want 0", err_timeout); end
    step(1'b1, 4'h1);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL to_relane_valid: got %b want 0", valid_out); end
    step(1'b1, 4'h2);
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL to_next_valid: got %b want 1", valid_out); end
    n_cmp++; if (data_out_0 !== 4'h1) begin n_err++; $display("FAIL to_next_d0: got %h want 1", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'h2) begin n_err++; $display("FAIL to_next_d1: got %h want 2", data_out_1); end
    n_cmp++; if (pair_count !== 8'd3) begin n_err++; $display("FAIL to_next_cnt: got %0d want 3", pair_count); end
  endtask

  task automatic test_boundary();
    step(1'b1, 4'h7);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    step(1'b1, 4'h9);
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL bnd_valid: got %b want 1", valid_out); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL bnd_err: got %b want 0", err_timeout); end
    n_cmp++; if (data_out_0 !== 4'h7) begin n_err++; $display("FAIL bnd_d0: got %h want 7", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'h9) begin n_err++; $display("FAIL bnd_d1: got %h want 9", data_out_1); end
    n_cmp++; if (pair_count !== 8'd4) begin n_err++; $display("FAIL bnd_cnt: got %0d want 4", pair_count); end
    step(1'b0, 4'h0);
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL bnd_err_after: got %b want 0", err_timeout); end
  endtask

  task automatic test_reset_mid_pair();
    step(1'b1, 4'hF);
    #2;
    reset_L = 1'b0;
    #1;
    n_cmp++; if (data_out_0 !== 4'h0) begin n_err++; $display("FAIL rst_mid_d0: got %h want 0", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'h0) begin n_err++; $display("FAIL rst_mid_d1: got %h want 0", data_out_1); end
    n_cmp++; if (pair_count !== 8'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d want 0", pair_count); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL rst_mid_err: got %b want 0", err_timeout); end
    // Release and present the first word on the very next edge.
    @(negedge clk);
    reset_L  = 1'b1;
    valid_in = 1'b1;
    data_in  = 4'h4;
    @(posedge clk);
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_first_valid: got %b want 0", valid_out); end
    step(1'b1, 4'h8);
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL rst_pair_valid: got %b want 1", valid_out); end
    n_cmp++; if (data_out_0 !== 4'h4) begin n_err++; $display("FAIL rst_pair_d0: got %h want 4", data_out_0); end
    n_cmp++; if (data_out_1 !== 4'h8) begin n_err++; $display("FAIL rst_pair_d1: got %h want 8", data_out_1); end
    n_cmp++; if (pair_count !== 8'd1) begin n_err++; $display("FAIL rst_pair_cnt: got %0d want 1", pair_count); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] w0;
    logic [3:0] w1;
    logic [7:0] exp_cnt;
    @(negedge clk);
    reset_L  = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w0 = 4'(i);
      w1 = 4'(15 - (i % 16));
      exp_cnt = 8'(i + 1);
      step(1'b1, w0);
      n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_gap_valid[%0d]: got %b want 0", i, valid_out); end
      step(1'b1, w1);
      n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid_out); end
      n_cmp++; if (data_out_0 !== w0 || data_out_1 !== w1) begin
        n_err++; $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", i, data_out_0, data_out_1, w0, w1);
      end
      n_cmp++; if (pair_count !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, pair_count, exp_cnt); end
      n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL b2b_err[%0d]: got %b want 0", i, err_timeout); end
    end
    n_cmp++; if (pair_count !== 8'd0) begin n_err++; $display("FAIL wrap_cnt: got %0d want 0", pair_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_pair();
    test_gap();
    test_timeout();
    test_boundary();
    test_reset_mid_pair();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
